tluh_wide_a_arbiter: RTL and testbench
======================================

Name: tluh_wide_a_arbiter

Overview:
- N-master to 1-slave arbiter for the wide TL-UH fabric (128-bit data, 28-bit address, 2-bit source).
- Round-robin arbitration on channel A with burst lock and valid-hold.
- Channel D is routed back to the owning master by the top source bits.
- Sits between the CPU-side TL-UH masters (e.g. icache, dcache uncached path, DMA) and a single wide TL-UH slave or crossbar port.

Parameters:
- N_MASTERS, 2, number of upstream masters (2..4).
- SEL_W, $clog2(N_MASTERS), count of top a_source/d_source bits that identify the master; must be <= TL_RS.

Ports:
- tilelink_clock_i  in  1  fabric clock.
- tilelink_reset_i  in  1  asynchronous, active-high reset.
- m_m2s_i  in  N_MASTERS x $bits(tluh_wide::tluh_m2s)  master requests (A channel plus d_ready).
- m_s2m_o  out  N_MASTERS x $bits(tluh_wide::tluh_s2m)  master responses (D channel plus a_ready).
- s_m2s_o  out  $bits(tluh_wide::tluh_m2s)  to slave.
- s_s2m_i  in  $bits(tluh_wide::tluh_s2m)  from slave.
- route_err_o  out  1  one-cycle pulse when a D beat carries an unmapped master index.

Behaviour:
- Each master tags its own requests: a_source[TL_RS-1 -: SEL_W] == its index. The arbiter does not rewrite source.
- Beats per message: data-bearing messages have beats = (size > 4) ? 1 << (size - 4) : 1; all others have beats = 1.
  - A-channel data-bearing opcodes: PutFullData, PutPartialData, ArithmeticData, LogicalData. Get and Intent are always 1 beat.
  - D-channel data-bearing opcode: AccessAckData.
- Beat counter is 3 bits; maximum is 8 beats (size 7). Size > 7 is unrepresentable.
- State machine: IDLE, HOLD, BURST. Registers are state, grant_q (SEL_W bits), rr_ptr (SEL_W bits) and beat_cnt (3 bits).
- IDLE:
  - Combinational grant = first master with a_valid, searching from rr_ptr upward with wrap-around.
  - The granted master's A fields drive s_m2s_o; its a_ready = s a_ready; all other a_ready = 0.
  - If no master is valid: s a_valid = 0 and the A payload is don't-care (drive zeros).
  - On A fire with beats > 1: go to BURST, beat_cnt = beats - 1, grant_q = grant.
  - On A fire with beats == 1: stay in IDLE.
  - On valid without ready: go to HOLD, grant_q = grant.
  - On every first-beat fire: rr_ptr = grant + 1, modulo N_MASTERS.
- HOLD:
  - Grant is fixed to grant_q, so the slave sees a stable request. A newly valid higher-priority master must not steal the grant.
  - On fire: go to BURST (beats > 1, beat_cnt = beats - 1) or to IDLE, with the rr_ptr update as in IDLE.
  - If the held master drops a_valid (protocol violation), return to IDLE.
- BURST:
  - Grant is fixed to grant_q. beat_cnt decrements on each fire.
  - A fire with beat_cnt == 1 returns to IDLE.
  - Non-granted masters see a_ready = 0 throughout.
- Arbitration latency: 0 cycles; a request can fire in the cycle it is first presented.
- Channel D:
  - sel = d_source[TL_RS-1 -: SEL_W]. d_valid reaches only m_s2m_o[sel]; all D payload fields are broadcast to every master.
  - s d_ready = m_m2s_i[sel].d_ready.
  - If sel >= N_MASTERS: s d_ready = 1 (the beat is dropped), no master sees d_valid, and route_err_o pulses on each such beat.
  - D is stateless, so A and D fire independently in the same cycle.
- Reset (asynchronous, any time, including mid-burst): state = IDLE, rr_ptr = 0, grant_q = 0, beat_cnt = 0, route_err_o = 0.
  - s a_valid is combinational from the master inputs. The remainder of an interrupted burst is not tracked.

Decomposition:
- Add to package tluh_wide:
  - a function returning the beat count from opcode and size;
  - a function classifying an opcode as data-bearing;
  - constant TL_BEAT_LG = $clog2(TL_BW) = 4.
- Natural sub-module: tluh_rr_pick, a combinational round-robin priority picker (request vector and pointer in, one-hot plus index out). The top module holds the FSM and the muxes.

Test Plan:
- Both masters (N_MASTERS=2) assert a Get (size 4) every cycle with s a_ready = 1 -> grants alternate 0,1,0,1; no cycle has both a_ready high.
- Master 0 sends PutFullData size 6 (4 beats) while master 1 is valid throughout -> 4 consecutive master-0 beats, then master 1 is granted; master 1 a_ready = 0 during the burst.
- Slave holds a_ready = 0 for 3 cycles on master 1's Get while master 0 becomes valid with rr_ptr = 0 -> the master-1 payload stays stable on s_m2s_o and the Get fires when ready rises; master 0 is granted next.
- Slave returns AccessAckData size 5 (2 beats) with d_source = 2'b10 while master 1 d_ready toggles -> d_valid is seen only at master 1, beats complete on its d_ready, and master 0 d_valid = 0.
- Unmapped source: N_MASTERS=3, d_source = 2'b11 -> s d_ready = 1, route_err_o pulses once, and all master d_valid = 0.
- Assert reset during beat 2 of an 8-beat PutPartialData (size 7) -> IDLE and rr_ptr = 0 immediately; the next request is granted from master 0 as a fresh first beat.

Source files
------------

// File: rtl/tluh_wide_pkg.sv
// Shared TL-UH wide fabric definitions: bus widths, opcodes, channel structs
// and beat-count helpers used by the channel A arbiter.
package tluh_wide;

   localparam int TL_DW      = 128;
   localparam int TL_BW      = TL_DW / 8;
   localparam int TL_AW      = 28;
   localparam int TL_RS      = 2;
   localparam int TL_SZW     = 3;
   localparam int TL_SKW     = 1;
   localparam int TL_BEAT_LG = $clog2(TL_BW);

   localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] TL_A_ARITHMETIC_DATA  = 3'd2;
   localparam logic [2:0] TL_A_LOGICAL_DATA     = 3'd3;
   localparam logic [2:0] TL_A_GET              = 3'd4;
   localparam logic [2:0] TL_A_INTENT           = 3'd5;

   localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;
   localparam logic [2:0] TL_D_HINT_ACK        = 3'd2;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_HOLD,
      ARB_BURST
   } arb_state_e;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_RS-1:0]  a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_BW-1:0]  a_mask;
      logic [TL_DW-1:0]  a_data;
      logic              a_corrupt;
      logic              d_ready;
   } tluh_m2s;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [1:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_RS-1:0]  d_source;
      logic [TL_SKW-1:0] d_sink;
      logic              d_denied;
      logic [TL_DW-1:0]  d_data;
      logic              d_corrupt;
      logic              a_ready;
   } tluh_s2m;

   function automatic logic a_has_data(input logic [2:0] op);
      return (op == TL_A_PUT_FULL_DATA)    || (op == TL_A_PUT_PARTIAL_DATA) ||
             (op == TL_A_ARITHMETIC_DATA)  || (op == TL_A_LOGICAL_DATA);
   endfunction

   function automatic logic d_has_data(input logic [2:0] op);
      return op == TL_D_ACCESS_ACK_DATA;
   endfunction

   // Messages wider than one data beat split into power-of-two beats.
   function automatic logic [3:0] tl_beats(input logic has_data, input logic [TL_SZW-1:0] size);
      logic [3:0] n;
      n = 4'd1;
      if (has_data && (size > TL_SZW'(TL_BEAT_LG))) begin
         n = 4'd1 << (size - TL_SZW'(TL_BEAT_LG));
      end
      return n;
   endfunction

   function automatic logic [3:0] a_beats(input logic [2:0] op, input logic [TL_SZW-1:0] size);
      return tl_beats(a_has_data(op), size);
   endfunction

   function automatic logic [3:0] d_beats(input logic [2:0] op, input logic [TL_SZW-1:0] size);
      return tl_beats(d_has_data(op), size);
   endfunction

endpackage

// File: rtl/tluh_wide_a_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping around, reported both one-hot and as an index.
module tluh_rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_oh_o,
   output logic [W-1:0] gnt_idx_o,
   output logic         gnt_any_o
);

   always_comb begin
      int pos;
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      pos       = 0;
      for (int i = 0; i < N; i++) begin
         pos = int'(ptr_i) + i;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!gnt_any_o && req_i[pos]) begin
            gnt_any_o     = 1'b1;
            gnt_oh_o[pos] = 1'b1;
            gnt_idx_o     = W'(pos);
         end
      end
   end

endmodule

// File: rtl/tluh_wide_a_arbiter.sv
// N-master to 1-slave TL-UH arbiter: round-robin on channel A with valid-hold
// and burst lock; channel D steered back by the top source bits.
module tluh_wide_a_arbiter
   import tluh_wide::*;
#(
   parameter int N_MASTERS = 2,
   parameter int SEL_W     = $clog2(N_MASTERS)
) (
   input  logic    tilelink_clock_i,
   input  logic    tilelink_reset_i,
   input  tluh_m2s m_m2s_i [N_MASTERS],
   output tluh_s2m m_s2m_o [N_MASTERS],
   output tluh_m2s s_m2s_o,
   input  tluh_s2m s_s2m_i,
   output logic    route_err_o
);

   arb_state_e           state_q, state_d;
   logic [SEL_W-1:0]     grant_q, grant_d;
   logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [2:0]           beat_cnt_q, beat_cnt_d;
   logic                 route_err_q, route_err_d;

   logic [N_MASTERS-1:0] a_req, pick_oh, grant_oh;
   logic [SEL_W-1:0]     pick_idx, grant_sel, grant_next, d_sel;
   logic                 pick_any, a_active, a_fire;
   logic [3:0]           a_beats_cur;
   logic                 d_mapped, d_ready_sel;

   always_comb begin
      a_req = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         a_req[i] = m_m2s_i[i].a_valid;
      end
   end

   tluh_rr_pick #(
      .N (N_MASTERS),
      .W (SEL_W)
   ) u_pick (
      .req_i     (a_req),
      .ptr_i     (rr_ptr_q),
      .gnt_oh_o  (pick_oh),
      .gnt_idx_o (pick_idx),
      .gnt_any_o (pick_any)
   );

   // Outside IDLE the grant is frozen so a late higher-priority request cannot steal it.
   always_comb begin
      grant_sel = grant_q;
      grant_oh  = '0;
      a_active  = 1'b0;
      if (state_q == ARB_IDLE) begin
         grant_sel = pick_idx;
         grant_oh  = pick_oh;
         a_active  = pick_any;
      end else begin
         for (int i = 0; i < N_MASTERS; i++) begin
            grant_oh[i] = (grant_q == SEL_W'(i));
         end
         a_active = m_m2s_i[grant_q].a_valid;
      end
      a_fire      = a_active && s_s2m_i.a_ready;
      grant_next  = (int'(grant_sel) == N_MASTERS - 1) ? '0 : grant_sel + 1'b1;
      a_beats_cur = a_beats(m_m2s_i[grant_sel].a_opcode, m_m2s_i[grant_sel].a_size);
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         ARB_IDLE, ARB_HOLD: begin
            if (a_fire) begin
               rr_ptr_d = grant_next;
               if (a_beats_cur > 4'd1) begin
                  state_d    = ARB_BURST;
                  beat_cnt_d = 3'(a_beats_cur - 4'd1);
                  grant_d    = grant_sel;
               end else begin
                  state_d = ARB_IDLE;
               end
            end else if (a_active) begin
               state_d = ARB_HOLD;
               grant_d = grant_sel;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_BURST: begin
            if (a_fire) begin
               beat_cnt_d = beat_cnt_q - 3'd1;
               if (beat_cnt_q == 3'd1) begin
                  state_d = ARB_IDLE;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Unmapped D beats are sunk here so a stray source cannot wedge the slave.
   always_comb begin
      d_sel       = s_s2m_i.d_source[TL_RS-1 -: SEL_W];
      d_mapped    = int'(d_sel) < N_MASTERS;
      d_ready_sel = !d_mapped;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (d_mapped && (d_sel == SEL_W'(i))) begin
            d_ready_sel = m_m2s_i[i].d_ready;
         end
      end
      route_err_d = s_s2m_i.d_valid && !d_mapped;
   end

   always_comb begin
      s_m2s_o = '0;
      if (a_active) begin
         s_m2s_o = m_m2s_i[grant_sel];
      end
      s_m2s_o.a_valid = a_active;
      s_m2s_o.d_ready = d_ready_sel;
   end

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         m_s2m_o[i]         = s_s2m_i;
         m_s2m_o[i].d_valid = s_s2m_i.d_valid && d_mapped && (d_sel == SEL_W'(i));
         m_s2m_o[i].a_ready = a_active && grant_oh[i] && s_s2m_i.a_ready;
      end
   end

   always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
      if (tilelink_reset_i) begin
         state_q     <= ARB_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         route_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         route_err_q <= route_err_d;
      end
   end

   assign route_err_o = route_err_q;

endmodule

// File: tb/tb_tluh_wide_a_arbiter.sv
// Directed bench for tluh_wide_a_arbiter: a vector table for channel A
// arbitration plus hand sequences for reset mid-burst and channel D routing.
module tb_tluh_wide_a_arbiter;
   import tluh_wide::*;

   localparam logic [27:0] A0 = 28'h100_0000;
   localparam logic [27:0] A1 = 28'h100_0010;

   typedef struct {
      logic [1:0]  valid;
      logic [2:0]  op0;
      logic [2:0]  sz0;
      logic        s_ready;
      logic        exp_valid;
      logic [27:0] exp_addr;
      logic [1:0]  exp_ready;
   } vec_t;

   logic    clk = 1'b0;
   logic    rst;
   tluh_m2s m2s2 [2];
   tluh_s2m s2m_o2 [2];
   tluh_m2s s_m2s2;
   tluh_s2m s_s2m2;
   logic    err2;
   tluh_m2s m2s3 [3];
   tluh_s2m s2m_o3 [3];
   tluh_m2s s_m2s3;
   tluh_s2m s_s2m3;
   logic    err3;

   int      checks = 0;
   int      errors = 0;
   vec_t    vecs [15];

   always #5 clk = ~clk;

   tluh_wide_a_arbiter #(.N_MASTERS(2)) dut2 (
      .tilelink_clock_i (clk),
      .tilelink_reset_i (rst),
      .m_m2s_i          (m2s2),
      .m_s2m_o          (s2m_o2),
      .s_m2s_o          (s_m2s2),
      .s_s2m_i          (s_s2m2),
      .route_err_o      (err2)
   );

   tluh_wide_a_arbiter #(.N_MASTERS(3)) dut3 (
      .tilelink_clock_i (clk),
      .tilelink_reset_i (rst),
      .m_m2s_i          (m2s3),
      .m_s2m_o          (s2m_o3),
      .s_m2s_o          (s_m2s3),
      .s_s2m_i          (s_s2m3),
      .route_err_o      (err3)
   );

   function automatic tluh_m2s mk_a(input int idx, input logic v, input logic [2:0] op,
                                    input logic [2:0] sz);
      tluh_m2s r;
      r           = '0;
      r.a_valid   = v;
      r.a_opcode  = op;
      r.a_size    = sz;
      r.a_source  = (idx == 1) ? 2'b10 : 2'b00;
      r.a_address = 28'h100_0000 + 28'(idx * 16);
      r.a_mask    = '1;
      r.a_data    = {4{32'hA0A0_0000 + 32'(idx)}};
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      m2s2[0]        = mk_a(0, v.valid[0], v.op0, v.sz0);
      m2s2[1]        = mk_a(1, v.valid[1], TL_A_GET, 3'd4);
      s_s2m2.a_ready = v.s_ready;
   endtask

   initial begin
      logic [3:0]   rdy_pat;
      logic [127:0] dexp;
      int           beat;

      // Rows: alternating Gets, 4-beat burst from master 0, hold on master 1, idle.
      vecs[0]  = '{2'b11, TL_A_GET,           3'd4, 1'b1, 1'b1, A0, 2'b01};
      vecs[1]  = '{2'b11, TL_A_GET,           3'd4, 1'b1, 1'b1, A1, 2'b10};
      vecs[2]  = '{2'b11, TL_A_GET,           3'd4, 1'b1, 1'b1, A0, 2'b01};
      vecs[3]  = '{2'b11, TL_A_GET,           3'd4, 1'b1, 1'b1, A1, 2'b10};
      vecs[4]  = '{2'b11, TL_A_PUT_FULL_DATA, 3'd6, 1'b1, 1'b1, A0, 2'b01};
      vecs[5]  = '{2'b11, TL_A_PUT_FULL_DATA, 3'd6, 1'b1, 1'b1, A0, 2'b01};
      vecs[6]  = '{2'b11, TL_A_PUT_FULL_DATA, 3'd6, 1'b1, 1'b1, A0, 2'b01};
      vecs[7]  = '{2'b11, TL_A_PUT_FULL_DATA, 3'd6, 1'b1, 1'b1, A0, 2'b01};
      vecs[8]  = '{2'b11, TL_A_PUT_FULL_DATA, 3'd6, 1'b1, 1'b1, A1, 2'b10};
      vecs[9]  = '{2'b10, TL_A_GET,           3'd4, 1'b0, 1'b1, A1, 2'b00};
      vecs[10] = '{2'b11, TL_A_GET,           3'd4, 1'b0, 1'b1, A1, 2'b00};
      vecs[11] = '{2'b11, TL_A_GET,           3'd4, 1'b0, 1'b1, A1, 2'b00};
      vecs[12] = '{2'b11, TL_A_GET,           3'd4, 1'b1, 1'b1, A1, 2'b10};
      vecs[13] = '{2'b01, TL_A_GET,           3'd4, 1'b1, 1'b1, A0, 2'b01};
      vecs[14] = '{2'b00, TL_A_GET,           3'd4, 1'b1, 1'b0, 28'h0, 2'b00};

      rst    = 1'b1;
      m2s2   = '{default: '0};
      m2s3   = '{default: '0};
      s_s2m2 = '0;
      s_s2m3 = '0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_s_a_valid", 128'(s_m2s2.a_valid), 128'(1'b0));
      checkOutput("reset_route_err", 128'(err3), 128'(1'b0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("row%0d_a_valid", i), 128'(s_m2s2.a_valid), 128'(vecs[i].exp_valid));
         checkOutput($sformatf("row%0d_a_addr", i), 128'(s_m2s2.a_address), 128'(vecs[i].exp_addr));
         checkOutput($sformatf("row%0d_a_ready", i),
                     128'({s2m_o2[1].a_ready, s2m_o2[0].a_ready}), 128'(vecs[i].exp_ready));
      end

      // Reset during beat 2 of an 8-beat PutPartialData from master 0 (rr_ptr is 1 here).
      @(negedge clk);
      m2s2[0]        = mk_a(0, 1'b1, TL_A_PUT_PARTIAL_DATA, 3'd7);
      m2s2[1]        = mk_a(1, 1'b0, TL_A_GET, 3'd4);
      s_s2m2.a_ready = 1'b1;
      #1;
      checkOutput("burst_beat1_ready", 128'({s2m_o2[1].a_ready, s2m_o2[0].a_ready}), 128'(2'b01));
      @(negedge clk);
      #1;
      checkOutput("burst_beat2_ready", 128'({s2m_o2[1].a_ready, s2m_o2[0].a_ready}), 128'(2'b01));
      #2;
      rst     = 1'b1;
      m2s2[0] = mk_a(0, 1'b0, TL_A_PUT_PARTIAL_DATA, 3'd7);
      m2s2[1] = mk_a(1, 1'b1, TL_A_GET, 3'd4);
      #1;
      checkOutput("in_reset_a_valid", 128'(s_m2s2.a_valid), 128'(1'b1));
      checkOutput("in_reset_a_addr", 128'(s_m2s2.a_address), 128'(A1));
      checkOutput("in_reset_a_ready", 128'({s2m_o2[1].a_ready, s2m_o2[0].a_ready}), 128'(2'b10));
      @(negedge clk);
      rst     = 1'b0;
      m2s2[0] = mk_a(0, 1'b1, TL_A_GET, 3'd4);
      m2s2[1] = mk_a(1, 1'b1, TL_A_GET, 3'd4);
      #1;
      checkOutput("post_reset_a_addr", 128'(s_m2s2.a_address), 128'(A0));
      checkOutput("post_reset_a_ready", 128'({s2m_o2[1].a_ready, s2m_o2[0].a_ready}), 128'(2'b01));

      // Two-beat AccessAckData to master 1 while its d_ready toggles.
      @(negedge clk);
      m2s2[0]         = mk_a(0, 1'b0, TL_A_GET, 3'd4);
      m2s2[1]         = mk_a(1, 1'b0, TL_A_GET, 3'd4);
      m2s2[0].d_ready = 1'b1;
      rdy_pat         = 4'b1010;
      beat            = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         dexp              = 128'h0D00 + 128'(beat);
         s_s2m2.d_valid    = 1'b1;
         s_s2m2.d_opcode   = TL_D_ACCESS_ACK_DATA;
         s_s2m2.d_size     = 3'd5;
         s_s2m2.d_source   = 2'b10;
         s_s2m2.d_data     = dexp;
         m2s2[1].d_ready   = rdy_pat[c];
         #1;
         checkOutput($sformatf("d%0d_m1_valid", c), 128'(s2m_o2[1].d_valid), 128'(1'b1));
         checkOutput($sformatf("d%0d_m0_valid", c), 128'(s2m_o2[0].d_valid), 128'(1'b0));
         checkOutput($sformatf("d%0d_s_ready", c), 128'(s_m2s2.d_ready), 128'(rdy_pat[c]));
         checkOutput($sformatf("d%0d_m0_data", c), s2m_o2[0].d_data, dexp);
         if (rdy_pat[c]) beat++;
      end
      @(negedge clk);
      s_s2m2.d_valid = 1'b0;
      #1;
      checkOutput("d_done_m1_valid", 128'(s2m_o2[1].d_valid), 128'(1'b0));

      // Three masters: mapped source 2'b10 reaches master 2, 2'b11 is dropped.
      @(negedge clk);
      s_s2m3.d_valid   = 1'b1;
      s_s2m3.d_opcode  = TL_D_ACCESS_ACK;
      s_s2m3.d_source  = 2'b10;
      m2s3[2].d_ready  = 1'b0;
      #1;
      checkOutput("n3_m2_valid", 128'(s2m_o3[2].d_valid), 128'(1'b1));
      checkOutput("n3_m0_valid", 128'(s2m_o3[0].d_valid), 128'(1'b0));
      checkOutput("n3_mapped_s_ready", 128'(s_m2s3.d_ready), 128'(1'b0));
      @(negedge clk);
      s_s2m3.d_source = 2'b11;
      #1;
      checkOutput("unmapped_s_ready", 128'(s_m2s3.d_ready), 128'(1'b1));
      checkOutput("unmapped_d_valids",
                  128'({s2m_o3[2].d_valid, s2m_o3[1].d_valid, s2m_o3[0].d_valid}), 128'(3'b000));
      checkOutput("unmapped_err_before", 128'(err3), 128'(1'b0));
      @(negedge clk);
      s_s2m3.d_valid = 1'b0;
      #1;
      checkOutput("unmapped_err_pulse", 128'(err3), 128'(1'b1));
      @(negedge clk);
      #1;
      checkOutput("unmapped_err_clear", 128'(err3), 128'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
